// File: rtl/count_done_monitor.sv
// count_done_monitor: observes a saturating up-counter, measures the number of
// cycles it takes to go from 0 to TARGET, checks that it only holds or steps
// by +1 (and holds once terminal), and reports each run as one event record on
// a valid/ready interface followed by a level `done`.
module count_done_monitor #(
  parameter int CNT_W  = 5,
  parameter int TARGET = 5,
  parameter int CYC_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] count_in,
  input  logic             clr,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [CYC_W-1:0] evt_cycles,
  output logic             evt_err,
  output logic             done,
  output logic             err_sticky
);

  typedef enum logic [1:0] {
    WAIT_ZERO = 2'd0,
    TRACK     = 2'd1,
    REPORT    = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TGT     = CNT_W'(TARGET);
  localparam logic [CYC_W-1:0] CYC_MAX = '1;

  // Saturating increment of the cycle measurement; never wraps.
  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (v == CYC_MAX) ? v : v + CYC_W'(1);
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] prev_q;
  logic [CYC_W-1:0] c_q;
  logic             run_err_q;
  logic             evt_valid_q;
  logic [CYC_W-1:0] evt_cycles_q;
  logic             evt_err_q;
  logic             done_q;
  logic             err_sticky_q;

  // Decoded view of the sampled counter value against the tracked history.
  logic             step_err;
  logic             at_tgt;
  logic             over_tgt;
  logic [CYC_W-1:0] c_d;

  // prev+1 is evaluated at CNT_W bits, so the legal successor wraps.
  assign step_err = (count_in != prev_q) && (count_in != prev_q + CNT_W'(1));
  assign at_tgt   = (count_in == TGT);
  assign over_tgt = (count_in > TGT);
  assign c_d      = sat_inc(c_q);

  // Monitor FSM and datapath; every output is a register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= WAIT_ZERO;
      prev_q       <= '0;
      c_q          <= '0;
      run_err_q    <= 1'b0;
      evt_valid_q  <= 1'b0;
      evt_cycles_q <= '0;
      evt_err_q    <= 1'b0;
      done_q       <= 1'b0;
      err_sticky_q <= 1'b0;
    end else if (clr) begin
      // Restart monitoring; a pending record is dropped.
      state_q      <= WAIT_ZERO;
      prev_q       <= '0;
      c_q          <= '0;
      run_err_q    <= 1'b0;
      evt_valid_q  <= 1'b0;
      evt_cycles_q <= '0;
      evt_err_q    <= 1'b0;
      done_q       <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      case (state_q)
        WAIT_ZERO: begin
          if (count_in == '0) begin
            c_q       <= '0;
            prev_q    <= '0;
            run_err_q <= 1'b0;
            state_q   <= TRACK;
          end
        end

        TRACK: begin
          prev_q <= count_in;
          if (step_err) begin
            run_err_q    <= 1'b1;
            err_sticky_q <= 1'b1;
          end
          if (at_tgt || over_tgt) begin
            // Terminal sample: this edge is counted in the measurement.
            evt_cycles_q <= c_d;
            evt_err_q    <= run_err_q | step_err | over_tgt;
            evt_valid_q  <= 1'b1;
            state_q      <= REPORT;
            if (over_tgt) begin
              err_sticky_q <= 1'b1;
            end
          end else if (c_d == CYC_MAX) begin
            // Timeout: the measurement has saturated without reaching TARGET.
            c_q          <= c_d;
            evt_cycles_q <= CYC_MAX;
            evt_err_q    <= 1'b1;
            err_sticky_q <= 1'b1;
            evt_valid_q  <= 1'b1;
            state_q      <= REPORT;
          end else begin
            c_q <= c_d;
          end
        end

        REPORT: begin
          // The record is latched; only the sticky flag can still change.
          if (!at_tgt) begin
            err_sticky_q <= 1'b1;
          end
          if (evt_valid_q && evt_ready) begin
            evt_valid_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
        end

        DONE: begin
          // The counter must hold at TARGET once the run is reported.
          if (!at_tgt) begin
            err_sticky_q <= 1'b1;
          end
        end

        default: state_q <= WAIT_ZERO;
      endcase
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_cycles = evt_cycles_q;
  assign evt_err    = evt_err_q;
  assign done       = done_q;
  assign err_sticky = err_sticky_q;

endmodule
